// File: rtl/mem_write_trace_pkg.sv
// Shared types for the RAM write tracer: record layout, emitter states, counter widths.
// Optional MEM_TRACE_TIMESTAMP_EN adds a 16-bit cycle stamp to each record.
package mem_trace_pkg;

    localparam int unsigned REC_ADDR_W = 15;
    localparam int unsigned REC_DATA_W = 16;
    localparam int unsigned STAMP_W    = 16;
    localparam int unsigned DROP_CNT_W = 8;

    typedef enum logic [1:0] {
        StIdle,
        StAddr,
        StData,
        StTime
    } beat_state_t;

    typedef struct packed {
        logic [REC_ADDR_W-1:0] addr;
        logic [REC_DATA_W-1:0] data;
`ifdef MEM_TRACE_TIMESTAMP_EN
        logic [STAMP_W-1:0]    stamp;
`endif
    } trace_rec_t;

endpackage

// File: rtl/mem_write_trace_if.sv
// Valid/ready word stream carrying replayed write records to the consumer.
interface mem_write_trace_if #(
    parameter int unsigned DATA_W = mem_trace_pkg::REC_DATA_W
);
    logic              out_valid;
    logic              out_ready;
    logic              out_last;
    logic [DATA_W-1:0] out_data;

    modport master (
        output out_valid,
        output out_data,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/mem_trace_fifo.sv
// Synchronous record FIFO; a push while full is taken only when a pop frees a slot on the same edge.
// Exposes the head and the entry behind it so the emitter can chain records without a bubble.
module mem_trace_fifo
    import mem_trace_pkg::*;
#(
    parameter int unsigned DEPTH = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   push_i,
    input  trace_rec_t             wdata_i,
    input  logic                   pop_i,
    output trace_rec_t             head_o,
    output trace_rec_t             next_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] level_o
);
    localparam int unsigned PTR_W = $clog2(DEPTH);

    trace_rec_t       mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   level_q, level_d;
    logic             do_push, do_pop;

    assign full_o  = level_q[PTR_W];
    assign empty_o = (level_q == '0);
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        unique case ({do_push, do_pop})
            2'b10:   level_d = level_q + (PTR_W + 1)'(1);
            2'b01:   level_d = level_q - (PTR_W + 1)'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign next_o  = mem_q[rd_ptr_q + PTR_W'(1)];
    assign level_o = level_q;

endmodule

// File: rtl/mem_write_trace.sv
// Snoops CPU RAM writes and replays each as ADDR/DATA(/TIME) beats on a valid/ready stream.
// Define MEM_TRACE_TIMESTAMP_EN to append a cycle-stamp TIME beat to every record.
module mem_write_trace
    import mem_trace_pkg::*;
#(
    parameter int unsigned ADDR_W = REC_ADDR_W,
    parameter int unsigned DATA_W = REC_DATA_W,
    parameter int unsigned DEPTH  = 16
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic                   trace_en,
    input  logic                   we,
    input  logic [ADDR_W-1:0]      ram_address,
    input  logic [DATA_W-1:0]      cpu_out_m,
    mem_write_trace_if.master      out_if,
    output logic                   overflow,
    output logic [DROP_CNT_W-1:0]  drop_cnt,
    output logic [$clog2(DEPTH):0] level
);
    localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

    beat_state_t           state_q, state_d;
    logic                  valid_q, valid_d;
    logic                  last_q, last_d;
    logic [DATA_W-1:0]     data_q, data_d;
    logic                  overflow_q, overflow_d;
    logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    trace_rec_t cap_rec, head_rec, next_rec, follow_rec;
    logic       capture, handshake, pop, drop, has_next, advance;
    logic       fifo_full, fifo_empty;
    logic [LVL_W-1:0] fifo_level;

`ifdef MEM_TRACE_TIMESTAMP_EN
    logic [STAMP_W-1:0] stamp_q, stamp_d;
    assign stamp_d = stamp_q + STAMP_W'(1);
`endif

    always_comb begin
        cap_rec      = '0;
        cap_rec.addr = REC_ADDR_W'(ram_address);
        cap_rec.data = REC_DATA_W'(cpu_out_m);
`ifdef MEM_TRACE_TIMESTAMP_EN
        cap_rec.stamp = stamp_q;
`endif
    end

    assign capture   = we && trace_en;
    assign handshake = valid_q && out_if.out_ready;
    assign pop       = handshake && last_q;
    assign drop      = capture && fifo_full && !pop;
    // Record after the one being popped: still queued, or the capture landing this edge.
    assign has_next   = (fifo_level > LVL_W'(1)) || capture;
    assign follow_rec = (fifo_level > LVL_W'(1)) ? next_rec : cap_rec;

    mem_trace_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (Clk),
        .rst_ni  (Reset),
        .push_i  (capture),
        .wdata_i (cap_rec),
        .pop_i   (pop),
        .head_o  (head_rec),
        .next_o  (next_rec),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (fifo_level)
    );

    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        data_d  = data_q;
        last_d  = last_q;
        advance = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    state_d = StAddr;
                    valid_d = 1'b1;
                    data_d  = DATA_W'(head_rec.addr);
                    last_d  = 1'b0;
                end
            end
            StAddr: begin
                if (handshake) begin
                    state_d = StData;
                    data_d  = DATA_W'(head_rec.data);
`ifdef MEM_TRACE_TIMESTAMP_EN
                    last_d  = 1'b0;
`else
                    last_d  = 1'b1;
`endif
                end
            end
            StData: begin
                if (handshake) begin
`ifdef MEM_TRACE_TIMESTAMP_EN
                    state_d = StTime;
                    data_d  = DATA_W'(head_rec.stamp);
                    last_d  = 1'b1;
`else
                    advance = 1'b1;
`endif
                end
            end
            StTime: begin
                if (handshake) advance = 1'b1;
            end
            default: state_d = StIdle;
        endcase

        if (advance) begin
            if (has_next) begin
                state_d = StAddr;
                valid_d = 1'b1;
                data_d  = DATA_W'(follow_rec.addr);
                last_d  = 1'b0;
            end else begin
                state_d = StIdle;
                valid_d = 1'b0;
                data_d  = '0;
                last_d  = 1'b0;
            end
        end
    end

    assign overflow_d = overflow_q || drop;
    assign drop_cnt_d = (drop && (drop_cnt_q != '1)) ? drop_cnt_q + DROP_CNT_W'(1) : drop_cnt_q;

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q    <= StIdle;
            valid_q    <= 1'b0;
            data_q     <= '0;
            last_q     <= 1'b0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
`ifdef MEM_TRACE_TIMESTAMP_EN
            stamp_q    <= '0;
`endif
        end else begin
            state_q    <= state_d;
            valid_q    <= valid_d;
            data_q     <= data_d;
            last_q     <= last_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
`ifdef MEM_TRACE_TIMESTAMP_EN
            stamp_q    <= stamp_d;
`endif
        end
    end

    assign out_if.out_valid = valid_q;
    assign out_if.out_data  = data_q;
    assign out_if.out_last  = last_q;
    assign overflow         = overflow_q;
    assign drop_cnt         = drop_cnt_q;
    assign level            = fifo_level;

endmodule

// File: tb/tb_mem_write_trace.sv
// Bench for mem_write_trace: directed table, corner sequences and a random run vs. a queue model.
module tb_mem_write_trace;
    localparam int unsigned DEPTH = 4;

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic        trace_en = 1'b1;
    logic        we = 1'b0;
    logic [14:0] ram_address = '0;
    logic [15:0] cpu_out_m = '0;
    logic        overflow;
    logic [7:0]  drop_cnt;
    logic [2:0]  level;

    mem_write_trace_if #(.DATA_W(16)) bus ();

    mem_write_trace #(
        .ADDR_W (15),
        .DATA_W (16),
        .DEPTH  (DEPTH)
    ) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .trace_en    (trace_en),
        .we          (we),
        .ram_address (ram_address),
        .cpu_out_m   (cpu_out_m),
        .out_if      (bus),
        .overflow    (overflow),
        .drop_cnt    (drop_cnt),
        .level       (level)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [15:0] d;
        logic        l;
    } beat_t;

    typedef struct {
        logic        we;
        logic [14:0] a;
        logic [15:0] d;
        logic        ev;
        logic [15:0] ed;
        logic        el;
        int          elvl;
    } vec_t;

    // Reference model: records counted until their last beat is taken, beats in stream order.
    beat_t       eb[$];
    logic [15:0] got[$];
    int          fifo_n = 0;
    int          drops = 0;
    bit          ovf = 1'b0;
    logic [15:0] stamp = '0;
    int          n_vec = 0;
    int          n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        bit          cap, hs, hold, rst;
        logic [15:0] pd;
        logic        pl;
        int          szb;
        cap  = we && trace_en;
        hs   = (bus.out_valid === 1'b1) && (bus.out_ready === 1'b1);
        hold = (bus.out_valid === 1'b1) && (bus.out_ready === 1'b0);
        pd   = bus.out_data;
        pl   = bus.out_last;
        rst  = !Reset;
        szb  = fifo_n;
        if (rst) begin
            eb.delete();
            fifo_n = 0;
            drops  = 0;
            ovf    = 1'b0;
            stamp  = '0;
        end else begin
            if (hs) begin
                got.push_back(pd);
                if (eb.size() == 0) begin
                    chk("beat_unexpected", 32'(pd), 32'hFFFF_FFFF);
                end else begin
                    chk("beat_data", 32'(pd), 32'(eb[0].d));
                    chk("beat_last", 32'(pl), 32'(eb[0].l));
                    eb.pop_front();
                end
                if (pl) fifo_n--;
            end
            if (cap) begin
                if (fifo_n == DEPTH) begin
                    if (drops < 255) drops++;
                    ovf = 1'b1;
                end else begin
                    fifo_n++;
                    eb.push_back('{d: 16'(ram_address), l: 1'b0});
`ifdef MEM_TRACE_TIMESTAMP_EN
                    eb.push_back('{d: cpu_out_m, l: 1'b0});
                    eb.push_back('{d: stamp, l: 1'b1});
`else
                    eb.push_back('{d: cpu_out_m, l: 1'b1});
`endif
                end
            end
            stamp = stamp + 16'd1;
        end
        @(posedge Clk);
        #1;
        chk("level", 32'(level), 32'(fifo_n));
        chk("overflow", 32'(overflow), 32'(ovf));
        chk("drop_cnt", 32'(drop_cnt), 32'(drops));
        if (rst) begin
            chk("rst_valid", 32'(bus.out_valid), 0);
            chk("rst_data", 32'(bus.out_data), 0);
            chk("rst_last", 32'(bus.out_last), 0);
        end else begin
            // Valid follows one edge behind the queue becoming non-empty, with no gaps after.
            chk("out_valid", 32'(bus.out_valid), 32'((szb > 0) && (fifo_n > 0)));
            if (hold) begin
                chk("hold_data", 32'(bus.out_data), 32'(pd));
                chk("hold_last", 32'(bus.out_last), 32'(pl));
            end
        end
    endtask

    task automatic drain();
        bus.out_ready = 1'b1;
        we = 1'b0;
        for (int k = 0; k < 100 && (fifo_n > 0 || bus.out_valid === 1'b1); k++) tick();
        chk("drain_done", 32'(fifo_n), 0);
    endtask

    task automatic do_reset();
        we = 1'b0;
        Reset = 1'b0;
        tick();
        Reset = 1'b1;
        tick();
    endtask

    vec_t tbl[12];

    initial begin
        bus.out_ready = 1'b1;
        tbl[0]  = '{1, 15'h0010, 16'h00AB, 0, 16'h0000, 0, 1};
        tbl[1]  = '{0, 15'h0000, 16'h0000, 1, 16'h0010, 0, 1};
        tbl[2]  = '{0, 15'h0000, 16'h0000, 1, 16'h00AB, 1, 1};
        tbl[3]  = '{0, 15'h0000, 16'h0000, 0, 16'h0000, 0, 0};
        tbl[4]  = '{1, 15'h0000, 16'h0005, 0, 16'h0000, 0, 1};
        tbl[5]  = '{1, 15'h0001, 16'h0006, 1, 16'h0000, 0, 2};
        tbl[6]  = '{1, 15'h0002, 16'h0007, 1, 16'h0005, 1, 3};
        tbl[7]  = '{0, 15'h0000, 16'h0000, 1, 16'h0001, 0, 2};
        tbl[8]  = '{0, 15'h0000, 16'h0000, 1, 16'h0006, 1, 2};
        tbl[9]  = '{0, 15'h0000, 16'h0000, 1, 16'h0002, 0, 1};
        tbl[10] = '{0, 15'h0000, 16'h0000, 1, 16'h0007, 1, 1};
        tbl[11] = '{0, 15'h0000, 16'h0000, 0, 16'h0000, 0, 0};

        do_reset();

`ifndef MEM_TRACE_TIMESTAMP_EN
        // Single write then three back-to-back writes, ready held high.
        for (int i = 0; i < 12; i++) begin
            we          = tbl[i].we;
            ram_address = tbl[i].a;
            cpu_out_m   = tbl[i].d;
            tick();
            chk($sformatf("tbl%0d_valid", i), 32'(bus.out_valid), 32'(tbl[i].ev));
            chk($sformatf("tbl%0d_data", i), 32'(bus.out_data), 32'(tbl[i].ed));
            chk($sformatf("tbl%0d_last", i), 32'(bus.out_last), 32'(tbl[i].el));
            chk($sformatf("tbl%0d_level", i), 32'(level), 32'(tbl[i].elvl));
        end
`endif

        // Backpressure on the DATA beat.
        we = 1'b1; ram_address = 15'h0123; cpu_out_m = 16'hBEEF;
        tick();
        we = 1'b0;
        tick();
        tick();
        chk("bp_data_beat", 32'(bus.out_data), 32'hBEEF);
        bus.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_hold_data", 32'(bus.out_data), 32'hBEEF);
            chk("bp_no_pop", 32'(level), 1);
        end
        drain();

        // Overflow with ready low: six writes into a four-deep queue.
        do_reset();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            we = 1'b1; ram_address = 15'(16'h0040 + i); cpu_out_m = 16'h1000 + 16'(i);
            tick();
        end
        we = 1'b0;
        chk("ovf_level", 32'(level), 4);
        chk("ovf_flag", 32'(overflow), 1);
        chk("ovf_drops", 32'(drop_cnt), 2);
        got.delete();
        drain();
`ifndef MEM_TRACE_TIMESTAMP_EN
        chk("ovf_beats", 32'(got.size()), 8);
        for (int k = 0; k < 4 && got.size() == 8; k++) begin
            chk("ovf_addr_order", 32'(got[2*k]), 32'(16'h0040 + k));
            chk("ovf_data_order", 32'(got[2*k+1]), 32'(16'h1000 + k));
        end
`endif

        // Reset during the ADDR beat, then a clean record.
        bus.out_ready = 1'b0;
        we = 1'b1; ram_address = 15'h0055; cpu_out_m = 16'h1234;
        tick();
        we = 1'b0;
        tick();
        chk("mid_addr_valid", 32'(bus.out_valid), 1);
        Reset = 1'b0;
        tick();
        chk("mid_rst_valid", 32'(bus.out_valid), 0);
        chk("mid_rst_level", 32'(level), 0);
        Reset = 1'b1;
        tick();
        got.delete();
        bus.out_ready = 1'b1;
        we = 1'b1; ram_address = 15'h0066; cpu_out_m = 16'h4321;
        tick();
        drain();
        chk("post_rst_first", (got.size() > 0) ? 32'(got[0]) : 32'hDEAD, 32'h0066);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            Reset         = ($urandom_range(0, 299) != 0);
            trace_en      = ($urandom_range(0, 7) != 0);
            we            = $urandom_range(0, 1);
            ram_address   = 15'($urandom);
            cpu_out_m     = 16'($urandom);
            bus.out_ready = (i < 1000) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            tick();
        end
        trace_en = 1'b1;
        Reset = 1'b1;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_write_trace.md
# mem_write_trace

Hardware counterpart of the bench's data-memory write tracker: snoops the CPU-to-RAM write port of `cpu_garage` (write enable, 15-bit RAM address, 16-bit write data) and replays every captured write as a 16-bit valid/ready word stream to a downstream consumer (UART bridge, debug host, checker). Sits beside the RAM, passive on the CPU side; never stalls the CPU. Captures are buffered in a FIFO; overflow drops records and counts them.

## Interface
Parameters:
- `ADDR_W`, 15: RAM address width.
- `DATA_W`, 16: RAM data width and stream word width.
- `DEPTH`, 16: FIFO records, power of two, at least 2.

Ports:
- `Clk`, in, 1: single clock; all logic is on its rising edge.
- `Reset`, in, 1: synchronous, active-low.
- `trace_en`, in, 1: capture enable, sampled each cycle.
- `we`, in, 1: CPU RAM write strobe.
- `ram_address`, in, ADDR_W: write address.
- `cpu_out_m`, in, DATA_W: write data.
- `out_valid`, out, 1: stream word valid.
- `out_ready`, in, 1: consumer accepts the word.
- `out_data`, out, DATA_W: stream word.
- `out_last`, out, 1: final word of the record.
- `overflow`, out, 1: sticky; set on the first dropped record.
- `drop_cnt`, out, 8: dropped-record count, saturating at 255.
- `level`, out, $clog2(DEPTH)+1: FIFO occupancy.

## Operation
- Capture happens in any cycle where `we && trace_en`. The record {ram_address, cpu_out_m} is pushed on that edge.
- Each record is emitted as beats:
  - ADDR beat: `out_data = {1'b0, ram_address}`.
  - DATA beat: `out_data = cpu_out_m`.
  - TIME beat, only when configured (see Configuration).
- `out_last` is high on the final beat only.
- Emitter FSM states:
  - IDLE to ADDR when the FIFO is non-empty.
  - ADDR to DATA on handshake.
  - DATA to IDLE (or to TIME if configured) on handshake.
  - TIME to IDLE on handshake.
  - The FIFO entry is popped on the handshake of the last beat.
- A handshake is `out_valid && out_ready` at the rising edge.
- `out_valid`, `out_data` and `out_last` are registered. They hold stable while `out_valid && !out_ready`.
- Full FIFO:
  - Capture with no pop in the same cycle: the record is dropped, `overflow` is set, and `drop_cnt` is incremented (saturating).
  - Capture with a last-beat pop in the same cycle: the record is accepted, and `level` is unchanged.
- `trace_en` low: no captures. Records already queued still drain.
- Pointers wrap modulo DEPTH. `level` ranges from 0 to DEPTH.

## Timing
- Reset (`Reset == 0` at an edge) forces:
  - `out_valid = 0`, `out_data = 0`, `out_last = 0`
  - `overflow = 0`, `drop_cnt = 0`, `level = 0`
  - FSM to IDLE; the FIFO is emptied.
- Reset mid-record discards the partial record. No beat is replayed after reset.
- Capture-to-`out_valid` latency is 2 cycles with an empty FIFO and IDLE FSM:
  - Write at edge N.
  - FSM enters ADDR at edge N+1.
  - `out_valid` is high after edge N+1.
- With `out_ready` held high, throughput is one beat per cycle, with no bubble between records: the next ADDR beat follows the last beat directly when the FIFO is non-empty.
- `level` updates on the edge after a push or pop.

## Configuration
- `MEM_TRACE_TIMESTAMP_EN`:
  - Defined: a free-running 16-bit cycle counter (reset 0, wraps) is captured with each record. It is emitted as a third TIME beat carrying `out_last`. FIFO entry width grows by 16.
  - Undefined: no counter. Records are two beats, and `out_last` is on the DATA beat.

## Structure
- Package `mem_trace_pkg` holds:
  - `trace_rec_t` struct: addr, data, optional stamp.
  - `beat_state_t` enum: IDLE, ADDR, DATA, TIME.
  - `DROP_CNT_W = 8` constant.
- Sub-module `mem_trace_fifo`: synchronous FIFO with push, pop, full, empty, level, and a same-cycle push/pop-when-full rule. The top holds capture and FSM logic.

## Test plan
- Single write: `we=1`, address 0x0010, data 0x00AB, `out_ready=1` → beats 0x0010, then 0x00AB with `out_last`. `out_valid` rises 2 cycles after capture. `level` returns to 0.
- Back-to-back: writes to 0,1,2 with data 5,6,7 on consecutive cycles, `out_ready=1` → six contiguous beats 0,5,1,6,2,7 with no idle cycle.
- Backpressure: `out_ready` low for 5 cycles during the DATA beat → `out_data` and `out_last` are held constant, and no pop occurs.
- Overflow: DEPTH=4, `out_ready=0`, 6 writes → `level=4`, `overflow=1`, `drop_cnt=2`. The first 4 records then drain in order.
- Reset mid-record: assert `Reset=0` during the ADDR beat → `out_valid=0`, `level=0`, `drop_cnt=0`. The next write is emitted cleanly.
- With `MEM_TRACE_TIMESTAMP_EN`: writes at cycle counts 20 and 23 → TIME beats 20 and 23 with `out_last`. DATA beats carry no `out_last`.
